// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions: data/index widths, opcode constants,
// the ID/EX pipeline register layout and a source/destination match helper.
package wisc_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int OPC_W     = 5;
    localparam int FUNCT_W   = 2;
    localparam int IMM_W     = 8;
    localparam int CNT_W     = 16;

    typedef logic [DATA_W-1:0]    data_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [OPC_W-1:0]     opcode_t;

    localparam opcode_t OPC_ST   = 5'b10000;
    localparam opcode_t OPC_LD   = 5'b10001;
    localparam opcode_t OPC_BEQZ = 5'b01100;
    localparam opcode_t OPC_ALU  = 5'b11011;
    localparam opcode_t OPC_ADDI = 5'b01000;

    // Contents of the ID/EX pipeline register
    typedef struct packed {
        logic                 valid;
        opcode_t              opcode;
        logic [FUNCT_W-1:0]   funct;
        data_t                rs;
        data_t                rt;
        data_t                pc;
        logic [IMM_W-1:0]     imm;
        reg_idx_t             rs_idx;
        reg_idx_t             rt_idx;
        reg_idx_t             rd_idx;
        logic                 rs_used;
        logic                 rt_used;
        logic                 reg_wr;
        logic                 mem_rd;
    } ex_regs_t;

    // A used source operand depends on a stage that writes the same register
    function automatic logic src_hit(input logic used, input reg_idx_t src,
                                     input logic wr, input reg_idx_t dst);
        return used & wr & (src == dst);
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding selector for one EX source operand.
// EX/MEM result has priority over MEM/WB; no zero-register special case.
module fwd_mux
    import wisc_pkg::*;
(
    input  logic     use_i,
    input  reg_idx_t idx_i,
    input  data_t    latched_i,
    input  logic     exmem_wr_i,
    input  reg_idx_t exmem_idx_i,
    input  data_t    exmem_data_i,
    input  logic     memwb_wr_i,
    input  reg_idx_t memwb_idx_i,
    input  data_t    memwb_data_i,
    output data_t    data_o
);

    // Pick the youngest in-flight producer of this operand, else the latched value
    always_comb begin
        data_o = latched_i;
        if (src_hit(use_i, idx_i, exmem_wr_i, exmem_idx_i)) begin
            data_o = exmem_data_i;
        end else if (src_hit(use_i, idx_i, memwb_wr_i, memwb_idx_i)) begin
            data_o = memwb_data_i;
        end else begin
            data_o = latched_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard detection, stall counting and
// operand forwarding into the execute stage.
// Build option ID_EX_FWD_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB and only load-use hazards stall; when undefined,
// operands are the latched values and any RAW dependency on EX, EX/MEM or
// MEM/WB stalls decode and inserts a bubble.
module id_ex_stage
    import wisc_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  opcode_t              id_opcode,
    input  logic [FUNCT_W-1:0]   id_funct,
    input  data_t                id_rs_data,
    input  data_t                id_rt_data,
    input  data_t                id_pc,
    input  logic [IMM_W-1:0]     id_imm,
    input  reg_idx_t             id_rs_idx,
    input  reg_idx_t             id_rt_idx,
    input  reg_idx_t             id_rd_idx,
    input  logic                 id_rs_used,
    input  logic                 id_rt_used,
    input  logic                 id_reg_wr,
    input  logic                 id_mem_rd,
    input  logic                 flush,
    input  logic                 ex_hold,
    input  logic                 exmem_reg_wr,
    input  reg_idx_t             exmem_rd_idx,
    input  data_t                exmem_data,
    input  logic                 memwb_reg_wr,
    input  reg_idx_t             memwb_rd_idx,
    input  data_t                memwb_data,
    output logic                 ex_valid,
    output opcode_t              ex_opcode,
    output logic [FUNCT_W-1:0]   ex_funct,
    output data_t                ex_rs,
    output data_t                ex_rt,
    output data_t                ex_pc,
    output logic [IMM_W-1:0]     ex_imm,
    output reg_idx_t             ex_rd_idx,
    output logic                 ex_reg_wr,
    output logic                 ex_mem_rd,
    output logic                 id_stall,
    output logic [CNT_W-1:0]     stall_cnt
);

`ifdef ID_EX_FWD_EN
    localparam logic FWD_EN_C = 1'b1;
`else
    localparam logic FWD_EN_C = 1'b0;
`endif

    ex_regs_t         ex_q;
    ex_regs_t         ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    data_t            fwd_rs_s;
    data_t            fwd_rt_s;
    logic             load_use_s;
    logic             raw_any_s;
    logic             hazard_s;
    logic             id_stall_s;

    fwd_mux u_fwd_rs (
        .use_i        (ex_q.rs_used & FWD_EN_C),
        .idx_i        (ex_q.rs_idx),
        .latched_i    (ex_q.rs),
        .exmem_wr_i   (exmem_reg_wr),
        .exmem_idx_i  (exmem_rd_idx),
        .exmem_data_i (exmem_data),
        .memwb_wr_i   (memwb_reg_wr),
        .memwb_idx_i  (memwb_rd_idx),
        .memwb_data_i (memwb_data),
        .data_o       (fwd_rs_s)
    );

    fwd_mux u_fwd_rt (
        .use_i        (ex_q.rt_used & FWD_EN_C),
        .idx_i        (ex_q.rt_idx),
        .latched_i    (ex_q.rt),
        .exmem_wr_i   (exmem_reg_wr),
        .exmem_idx_i  (exmem_rd_idx),
        .exmem_data_i (exmem_data),
        .memwb_wr_i   (memwb_reg_wr),
        .memwb_idx_i  (memwb_rd_idx),
        .memwb_data_i (memwb_data),
        .data_o       (fwd_rt_s)
    );

    // Hazard detection: load-use when forwarding exists, any RAW dependency otherwise
    always_comb begin
        load_use_s = ex_q.valid & ex_q.mem_rd & ex_q.reg_wr & id_valid &
                     (src_hit(id_rs_used, id_rs_idx, 1'b1, ex_q.rd_idx) |
                      src_hit(id_rt_used, id_rt_idx, 1'b1, ex_q.rd_idx));
        raw_any_s  = id_valid &
                     (src_hit(id_rs_used, id_rs_idx, ex_q.valid & ex_q.reg_wr, ex_q.rd_idx) |
                      src_hit(id_rs_used, id_rs_idx, exmem_reg_wr, exmem_rd_idx) |
                      src_hit(id_rs_used, id_rs_idx, memwb_reg_wr, memwb_rd_idx) |
                      src_hit(id_rt_used, id_rt_idx, ex_q.valid & ex_q.reg_wr, ex_q.rd_idx) |
                      src_hit(id_rt_used, id_rt_idx, exmem_reg_wr, exmem_rd_idx) |
                      src_hit(id_rt_used, id_rt_idx, memwb_reg_wr, memwb_rd_idx));
        if (FWD_EN_C) begin
            hazard_s = load_use_s;
        end else begin
            hazard_s = raw_any_s;
        end
        // Reset and flush both discard whatever the stall would have protected
        id_stall_s = rst_n & ~flush & (ex_hold | hazard_s);
    end

    // Next pipeline register contents, priority flush > hold > hazard > normal
    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d.valid  = 1'b0;
            ex_d.reg_wr = 1'b0;
            ex_d.mem_rd = 1'b0;
        end else if (ex_hold) begin
            // Keep operands correct while later stages drain under the stall
            ex_d.rs = fwd_rs_s;
            ex_d.rt = fwd_rt_s;
        end else if (hazard_s) begin
            ex_d.valid  = 1'b0;
            ex_d.reg_wr = 1'b0;
            ex_d.mem_rd = 1'b0;
        end else begin
            ex_d.valid   = id_valid;
            ex_d.opcode  = id_opcode;
            ex_d.funct   = id_funct;
            ex_d.rs      = id_rs_data;
            ex_d.rt      = id_rt_data;
            ex_d.pc      = id_pc;
            ex_d.imm     = id_imm;
            ex_d.rs_idx  = id_rs_idx;
            ex_d.rt_idx  = id_rt_idx;
            ex_d.rd_idx  = id_rd_idx;
            ex_d.rs_used = id_rs_used;
            ex_d.rt_used = id_rt_used;
            ex_d.reg_wr  = id_valid & id_reg_wr;
            ex_d.mem_rd  = id_valid & id_mem_rd;
        end
    end

    // Saturating count of stalled decode cycles
    always_comb begin
        if (id_stall_s && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline register and stall counter with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            cnt_q <= 16'd0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid  = ex_q.valid;
    assign ex_opcode = ex_q.opcode;
    assign ex_funct  = ex_q.funct;
    assign ex_rs     = fwd_rs_s;
    assign ex_rt     = fwd_rt_s;
    assign ex_pc     = ex_q.pc;
    assign ex_imm    = ex_q.imm;
    assign ex_rd_idx = ex_q.rd_idx;
    assign ex_reg_wr = ex_q.reg_wr;
    assign ex_mem_rd = ex_q.mem_rd;
    assign id_stall  = id_stall_s;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have decode inputs id_valid 1, id_opcode 5, id_funct 2, id_rs_data 16, id_rt_data 16, id_pc 16, id_imm 8, id_rs_idx 3, id_rt_idx 3, id_rd_idx 3, id_rs_used 1, id_rt_used 1, id_reg_wr 1, id_mem_rd 1.
REQ-004 SHALL have control inputs flush 1 (squash ID/EX contents) and ex_hold 1 (downstream stall, freeze stage).
REQ-005 SHALL have forwarding inputs exmem_reg_wr 1, exmem_rd_idx 3, exmem_data 16, memwb_reg_wr 1, memwb_rd_idx 3, memwb_data 16.
REQ-006 SHALL have outputs ex_valid 1, ex_opcode 5, ex_funct 2, ex_rs 16, ex_rt 16, ex_pc 16, ex_imm 8, ex_rd_idx 3, ex_reg_wr 1, ex_mem_rd 1 feeding the ALU/execute stage.
REQ-007 SHALL have output id_stall 1 (decode must hold its instruction) and stall_cnt 16 (saturating count of cycles id_stall was 1).

Function
REQ-008 SHALL register all decode fields on a clock edge when not frozen, giving exactly one cycle ID-to-EX latency.
REQ-009 SHALL evaluate per cycle with priority flush > ex_hold > load-use > normal.
REQ-010 flush: next ex_valid=0, ex_reg_wr=0, ex_mem_rd=0; other fields don't-care; id_stall=0.
REQ-011 ex_hold (no flush): all registered fields hold, except ex_rs/ex_rt which capture their forwarded value (REQ-013) so operands stay correct while later stages drain; id_stall=1.
REQ-012 load-use: when ex_valid & ex_mem_rd & ex_reg_wr & id_valid and (id_rs_used & id_rs_idx==ex_rd_idx or id_rt_used & id_rt_idx==ex_rd_idx): id_stall=1, next ex_valid=0 (bubble, ex_reg_wr=0, ex_mem_rd=0).
REQ-013 ex_rs (ex_rt likewise) SHALL combinationally equal exmem_data if exmem_reg_wr & exmem_rd_idx==latched rs_idx, else memwb_data if memwb_reg_wr & memwb_rd_idx==latched rs_idx, else latched rs value; EX/MEM wins over MEM/WB on double match.
REQ-014 forwarding SHALL only apply when the latched rs_used/rt_used bit is 1; register index 0 is an ordinary register (no zero-register special case).
REQ-015 id_valid=0 with no freeze SHALL load a bubble (ex_valid=0, ex_reg_wr=0, ex_mem_rd=0).
REQ-016 id_stall SHALL be combinational from current-cycle inputs and state; it never asserts during flush.
REQ-017 stall_cnt SHALL increment by 1 each cycle id_stall=1 and saturate at 16'hFFFF.

Reset
REQ-018 rst_n=0 at clk edge SHALL clear ex_valid, ex_reg_wr, ex_mem_rd, all data/index fields and stall_cnt to 0; reset overrides flush/hold.
REQ-019 during reset cycle id_stall SHALL be 0; a load-use pending at reset SHALL be discarded.

Configuration
REQ-020 macro ID_EX_FWD_EN defined: forwarding per REQ-013/014 and stalls only per REQ-012.
REQ-021 ID_EX_FWD_EN undefined: ex_rs/ex_rt equal latched values; id_stall=1 and bubble inserted for any used source matching a valid writing destination in EX, EX/MEM or MEM/WB (reg_wr set).

Structure
REQ-022 opcode constants (load opcode 5'b10001 etc.), register-index width 3 and data width 16 SHALL live in shared package wisc_pkg.
REQ-023 forwarding selection SHALL be one sub-module fwd_mux instantiated twice (rs, rt).

Verification
REQ-024 reset then ADD r1,r2,r3 with id_rs_data=16'h0005, id_rt_data=16'h0003 -> next cycle ex_valid=1, ex_rs=5, ex_rt=3, id_stall=0.
REQ-025 exmem_reg_wr=1, exmem_rd_idx=2, exmem_data=16'hAAAA and memwb_rd_idx=2, memwb_data=16'h5555 with latched rs_idx=2 -> ex_rs=16'hAAAA.
REQ-026 LD r4 in EX, ID reads r4 as rt -> id_stall=1 one cycle, next ex_valid=0, following cycle dependent instr latched with id_stall=0.
REQ-027 flush and ex_hold both 1 with valid ID instruction -> next ex_valid=0, id_stall=0.
REQ-028 ex_hold=1 for 3 cycles while memwb forwards 16'h1234 to rs -> ex_rs=16'h1234 after hold releases; stall_cnt=3.
REQ-029 ID_EX_FWD_EN undefined, EX/MEM writing r3, ID reads r3 -> id_stall=1 until match clears.
